// File: rtl/peri_bus_arbiter_if.sv
// Bus bundle for peri_bus_arbiter: two requesting masters (m0 = CPU MEM
// stage, m1 = debug/UART bridge) plus the single peripheral slave port.
// The "slave" modport is the arbiter's view (it serves the masters).
// The "master" modport is the environment's view (masters and the peripheral).
interface peri_bus_arbiter_if;
  // master 0 request/response
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [31:0] m0_rdata;
  logic        m0_ack;
  logic        m0_err;

  // master 1 request/response
  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic [31:0] m1_rdata;
  logic        m1_ack;
  logic        m1_err;

  // peripheral register window
  logic        peri_cre_o;
  logic        peri_cwe_o;
  logic [31:0] peri_addr_o;
  logic [31:0] peri_wdata_o;
  logic [31:0] peri_rdata_i;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ack, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ack, m1_err,
    output peri_cre_o, peri_cwe_o, peri_addr_o, peri_wdata_o,
    input  peri_rdata_i
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack, m1_err,
    input  peri_cre_o, peri_cwe_o, peri_addr_o, peri_wdata_o,
    output peri_rdata_i
  );
endinterface

// File: rtl/peri_bus_arbiter.sv
// peri_bus_arbiter: round-robin arbitration of two masters onto one
// peripheral register window. Every transaction takes IDLE -> BUS -> RESP:
// request sampled in IDLE, slave strobe during BUS, ack pulse during RESP.
// Misaligned, out-of-window and writes to the read-only SYSTICK register are
// completed with err=1 and never reach the slave.
module peri_bus_arbiter #(
  parameter logic [31:0] PERI_BASE = 32'h4000_0000,
  parameter logic [31:0] PERI_LAST = 32'h4000_0014,
  parameter logic [31:0] RO_ADDR   = 32'h4000_0014
) (
  input logic               clk,
  input logic               rst,
  peri_bus_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // per-master views of the interface so the datapath can be indexed
  logic [1:0]  req_v;
  logic [1:0]  we_v;
  logic [1:0]  want_v;
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];

  // per-master registered responses
  logic        ack_reg   [2];
  logic        err_reg   [2];
  logic [31:0] rdata_reg [2];

  // arbiter state and the latched request of the granted master
  logic [1:0]  state_reg, state_next;
  logic        gnt_reg, gnt_next;
  logic        last_gnt_reg, last_gnt_next;
  logic        we_reg, we_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;

  logic        pick;
  logic        req_err;
  logic        in_bus;
  logic        strobe_en;

  assign req_v      = {bus.m1_req, bus.m0_req};
  assign we_v       = {bus.m1_we, bus.m0_we};
  assign addr_v[0]  = bus.m0_addr;
  assign addr_v[1]  = bus.m1_addr;
  assign wdata_v[0] = bus.m0_wdata;
  assign wdata_v[1] = bus.m1_wdata;

  assign bus.m0_ack   = ack_reg[0];
  assign bus.m0_err   = err_reg[0];
  assign bus.m0_rdata = rdata_reg[0];
  assign bus.m1_ack   = ack_reg[1];
  assign bus.m1_err   = err_reg[1];
  assign bus.m1_rdata = rdata_reg[1];

  // On a tie the master that did not win last time gets the bus; otherwise
  // the lone requester wins (want_v[1] selects m1 only when m1 is asking).
  assign pick = (want_v == 2'b11) ? ~last_gnt_reg : want_v[1];

  // Error classification is done on the latched request so that master-side
  // changes after the grant cannot affect it.
  assign req_err = (addr_reg[1:0] != 2'b00) ||
                   (addr_reg < PERI_BASE)   ||
                   (addr_reg > PERI_LAST)   ||
                   (we_reg && (addr_reg == RO_ADDR));

  assign in_bus    = (state_reg == ST_BUS);
  assign strobe_en = in_bus && !req_err;

  // Slave port: active only for a legal request during BUS. Address and data
  // are forced to zero otherwise, including erroneous requests, so the slave
  // never sees an address it was not meant to decode.
  assign bus.peri_cre_o   = strobe_en && !we_reg;
  assign bus.peri_cwe_o   = strobe_en && we_reg;
  assign bus.peri_addr_o  = strobe_en ? addr_reg  : 32'h0;
  assign bus.peri_wdata_o = strobe_en ? wdata_reg : 32'h0;

  // Next-state logic: grant and latch in IDLE, one BUS cycle, one RESP cycle.
  always_comb begin
    state_next    = state_reg;
    gnt_next      = gnt_reg;
    last_gnt_next = last_gnt_reg;
    we_next       = we_reg;
    addr_next     = addr_reg;
    wdata_next    = wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (want_v != 2'b00) begin
          gnt_next      = pick;
          last_gnt_next = pick;
          we_next       = we_v[pick];
          addr_next     = addr_v[pick];
          wdata_next    = wdata_v[pick];
          state_next    = ST_BUS;
        end
      end
      ST_BUS: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        // drop the latched request once it has been answered
        we_next    = 1'b0;
        addr_next  = 32'h0;
        wdata_next = 32'h0;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register; reset abandons any transaction in flight and lets m0 win
  // the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      gnt_reg      <= 1'b0;
      last_gnt_reg <= 1'b1;
      we_reg       <= 1'b0;
      addr_reg     <= 32'h0;
      wdata_reg    <= 32'h0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      last_gnt_reg <= last_gnt_next;
      we_reg       <= we_next;
      addr_reg     <= addr_next;
      wdata_reg    <= wdata_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      localparam logic IDX = 1'(gi);

      logic mine;

      // the granted master's BUS cycle is the one whose result gets registered
      assign mine = in_bus && (gnt_reg == IDX);

      // a master already seeing its ack is finishing, not asking again
      assign want_v[gi] = req_v[gi] && !ack_reg[gi];

      // Response registers: ack/err pulse during RESP; rdata captured at the
      // end of BUS and held until this master's next transaction.
      always_ff @(posedge clk) begin
        if (rst) begin
          ack_reg[gi]   <= 1'b0;
          err_reg[gi]   <= 1'b0;
          rdata_reg[gi] <= 32'h0;
        end else begin
          ack_reg[gi] <= mine;
          err_reg[gi] <= mine && req_err;
          if (mine) begin
            rdata_reg[gi] <= (!req_err && !we_reg) ? bus.peri_rdata_i : 32'h0;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// Testbench for peri_bus_arbiter: directed master transactions against a
// small register-file slave, with a transaction-level scheduling model that
// predicts every output on every cycle, plus literal latency/data checks.
module tb_peri_bus_arbiter;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] LAST = 32'h4000_0014;
  localparam logic [31:0] RO   = 32'h4000_0014;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  peri_bus_arbiter_if bus ();

  peri_bus_arbiter #(.PERI_BASE(BASE), .PERI_LAST(LAST), .RO_ADDR(RO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // master drive values
  logic        req_d   [2];
  logic        we_d    [2];
  logic [31:0] addr_d  [2];
  logic [31:0] wdata_d [2];

  assign bus.m0_req   = req_d[0];
  assign bus.m0_we    = we_d[0];
  assign bus.m0_addr  = addr_d[0];
  assign bus.m0_wdata = wdata_d[0];
  assign bus.m1_req   = req_d[1];
  assign bus.m1_we    = we_d[1];
  assign bus.m1_addr  = addr_d[1];
  assign bus.m1_wdata = wdata_d[1];

  logic [1:0]  ack_o;
  logic [1:0]  err_o;
  logic [31:0] rd_o [2];
  assign ack_o   = {bus.m1_ack, bus.m0_ack};
  assign err_o   = {bus.m1_err, bus.m0_err};
  assign rd_o[0] = bus.m0_rdata;
  assign rd_o[1] = bus.m1_rdata;

  // peripheral: six words, combinational read, write on strobe
  logic [31:0] smem [6] = '{32'h0, 32'h0, 32'h0, 32'h0000_00A5, 32'h0, 32'h0000_1234};

  function automatic int widx(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) >> 2;
    return (off < 6) ? int'(off) : 0;
  endfunction

  assign bus.peri_rdata_i = bus.peri_cre_o ? smem[widx(bus.peri_addr_o)] : 32'hDEAD_BEEF;

  always @(posedge clk) if (bus.peri_cwe_o) smem[widx(bus.peri_addr_o)] <= bus.peri_wdata_o;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit is_err(input bit we, input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < BASE) || (a > LAST) || (we && a == RO);
  endfunction

  // ---------------- transaction-level model ----------------
  // A granted request occupies cycles c (decision), c+1 (strobe), c+2 (ack);
  // the arbiter is free again at c+3.
  int          s_cyc   = -100;
  int          s_m     = 0;
  int          free_at = 0;
  int          last    = 1;
  bit          s_we, s_err;
  logic [31:0] s_addr, s_wdata, s_rd;
  logic [31:0] rd_exp [2] = '{32'h0, 32'h0};
  logic [31:0] mmem   [6] = '{32'h0, 32'h0, 32'h0, 32'h0000_00A5, 32'h0, 32'h0000_1234};

  always @(negedge clk) begin
    logic        e_cre, e_cwe;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_ack, e_err;
    logic [1:0]  want;
    int          g;
    if (cyc >= 1) begin
      e_cre = 0; e_cwe = 0; e_addr = 0; e_wdata = 0; e_ack = 0; e_err = 0;
      if (cyc == s_cyc) begin
        s_rd = 32'h0;
        if (!s_err) begin
          e_cre = !s_we; e_cwe = s_we; e_addr = s_addr; e_wdata = s_wdata;
          if (s_we) mmem[widx(s_addr)] = s_wdata;
          else      s_rd = mmem[widx(s_addr)];
        end
      end
      if (cyc == s_cyc + 1) begin
        e_ack[s_m] = 1'b1;
        e_err[s_m] = s_err;
        rd_exp[s_m] = s_rd;
      end
      chk($sformatf("peri_cre@%0d", cyc),   32'(bus.peri_cre_o), 32'(e_cre));
      chk($sformatf("peri_cwe@%0d", cyc),   32'(bus.peri_cwe_o), 32'(e_cwe));
      chk($sformatf("peri_addr@%0d", cyc),  bus.peri_addr_o,     e_addr);
      chk($sformatf("peri_wdata@%0d", cyc), bus.peri_wdata_o,    e_wdata);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d_ack@%0d", m, cyc),   32'(ack_o[m]), 32'(e_ack[m]));
        chk($sformatf("m%0d_err@%0d", m, cyc),   32'(err_o[m]), 32'(e_err[m]));
        chk($sformatf("m%0d_rdata@%0d", m, cyc), rd_o[m],       rd_exp[m]);
      end
      if (rst) begin
        s_cyc = -100; free_at = cyc + 1; last = 1;
        rd_exp[0] = 32'h0; rd_exp[1] = 32'h0;
      end else if (cyc >= free_at) begin
        want = {req_d[1] && !e_ack[1], req_d[0] && !e_ack[0]};
        if (want != 2'b00) begin
          if (want == 2'b11) g = (last == 0) ? 1 : 0;
          else               g = want[1] ? 1 : 0;
          last = g; s_m = g; s_cyc = cyc + 1; free_at = cyc + 3;
          s_we = we_d[g]; s_addr = addr_d[g]; s_wdata = wdata_d[g];
          s_err = is_err(we_d[g], addr_d[g]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Call at posedge+1. Raises the request, waits (bounded) for ack, reports
  // latency in cycles from request to ack, and optionally releases req.
  task automatic txn(input int m, input bit we, input logic [31:0] a, input logic [31:0] d,
                     input bit release_after, output int lat, output logic [31:0] rd,
                     output logic er);
    int t0;
    bit got;
    we_d[m] = we; addr_d[m] = a; wdata_d[m] = d; req_d[m] = 1'b1;
    t0 = cyc; got = 0; lat = -1; rd = 32'h0; er = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ack_o[m]) begin
        got = 1; lat = cyc - t0; rd = rd_o[m]; er = err_o[m];
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL m%0d_timeout: got no ack in 40 cycles, expected ack", m);
    end
    $display("txn m%0d we=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%0d",
             m, we, a, d, lat, rd, er);
    @(posedge clk); #1;
    if (release_after) req_d[m] = 1'b0;
  endtask

  initial begin
    int          l0, l1;
    logic [31:0] r0, r1;
    logic        e0, e1;
    int          done0;
    for (int m = 0; m < 2; m++) begin
      req_d[m] = 0; we_d[m] = 0; addr_d[m] = 0; wdata_d[m] = 0;
    end
    // reset held with a request pending: nothing may be granted
    req_d[1] = 1'b1; addr_d[1] = 32'h4000_0004;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_cre", 32'(bus.peri_cre_o), 32'h0);
    chk("rst_hold_ack1", 32'(bus.m1_ack), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; req_d[1] = 1'b0;
    @(posedge clk); #1;

    // simultaneous writes after reset: m0 first, m1 three cycles later
    fork
      txn(0, 1'b1, 32'h4000_0004, 32'h1111_1111, 1'b1, l0, r0, e0);
      txn(1, 1'b1, 32'h4000_0008, 32'h2222_2222, 1'b1, l1, r1, e1);
    join
    chk("pair1_m0_lat", l0, 2);
    chk("pair1_m1_lat", l1, 5);
    // last grant was m1, so the next tie goes to m0 again
    fork
      txn(0, 1'b1, 32'h4000_0010, 32'h3333_3333, 1'b1, l0, r0, e0);
      txn(1, 1'b1, 32'h4000_0000, 32'h4444_4444, 1'b1, l1, r1, e1);
    join
    chk("pair2_m0_lat", l0, 2);
    chk("pair2_m1_lat", l1, 5);

    // read of a preloaded register
    txn(0, 1'b0, 32'h4000_000C, 32'h0, 1'b1, l0, r0, e0);
    chk("rd0C_lat", l0, 2);
    chk("rd0C_rdata", r0, 32'h0000_00A5);
    chk("rd0C_err", 32'(e0), 32'h0);
    // read back what m1 wrote
    txn(1, 1'b0, 32'h4000_0008, 32'h0, 1'b1, l1, r1, e1);
    chk("rd08_rdata", r1, 32'h2222_2222);

    // write to read-only SYSTICK
    txn(1, 1'b1, RO, 32'h0000_0005, 1'b1, l1, r1, e1);
    chk("ro_wr_lat", l1, 2);
    chk("ro_wr_err", 32'(e1), 32'h1);
    chk("ro_wr_rdata", r1, 32'h0);
    // reading SYSTICK is legal
    txn(0, 1'b0, RO, 32'h0, 1'b1, l0, r0, e0);
    chk("ro_rd_err", 32'(e0), 32'h0);
    chk("ro_rd_rdata", r0, 32'h0000_1234);
    // misaligned, past the window, below the window
    txn(0, 1'b0, 32'h4000_0002, 32'h0, 1'b1, l0, r0, e0);
    chk("misal_lat", l0, 2);
    chk("misal_err", 32'(e0), 32'h1);
    txn(0, 1'b0, 32'h4000_0018, 32'h0, 1'b1, l0, r0, e0);
    chk("above_err", 32'(e0), 32'h1);
    chk("above_rdata", r0, 32'h0);
    txn(0, 1'b0, 32'h3FFF_FFFC, 32'h0, 1'b1, l0, r0, e0);
    chk("below_err", 32'(e0), 32'h1);

    // reset during BUS abandons the write without an ack
    we_d[0] = 1'b1; addr_d[0] = 32'h4000_0000; wdata_d[0] = 32'hFFFF_FF00; req_d[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1; req_d[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("abandon_ack0_%0d", k), 32'(bus.m0_ack), 32'h0);
      chk($sformatf("abandon_rdata0_%0d", k), bus.m0_rdata, 32'h0);
    end
    @(posedge clk); #1;
    txn(0, 1'b1, 32'h4000_0000, 32'hFFFF_FF00, 1'b1, l0, r0, e0);
    chk("rereq_lat", l0, 2);
    chk("rereq_err", 32'(e0), 32'h0);
    txn(0, 1'b0, 32'h4000_0000, 32'h0, 1'b1, l0, r0, e0);
    chk("rereq_readback", r0, 32'hFFFF_FF00);

    // m0 hammers the bus; m1 must still get through promptly
    done0 = 0;
    fork
      begin
        for (int k = 0; k < 10; k++) begin
          txn(0, 1'(k % 2), BASE + 32'(4 * (k % 5)), 32'(k) * 32'h0101_0101,
              1'(k == 9), l0, r0, e0);
          if (l0 > 0) done0++;
        end
      end
      begin
        repeat (4) @(posedge clk); #1;
        txn(1, 1'b0, 32'h4000_0004, 32'h0, 1'b1, l1, r1, e1);
      end
    join
    chk("fair_m1_within6", 32'(l1 >= 2 && l1 <= 6), 32'h1);
    chk("fair_m0_done", done0, 10);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // absolute safety bound on simulation time
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish within 20000 cycles");
    $fatal(1);
  end

endmodule

// File: doc/peri_bus_arbiter.md
PERI_BUS_ARBITER -- requirements
Module: peri_bus_arbiter

Interface
REQ-001 SHALL have parameter PERI_BASE, default 32'h4000_0000, base address of the peripheral register window.
REQ-002 SHALL have parameter PERI_LAST, default 32'h4000_0014, highest valid word address in the window.
REQ-003 SHALL have parameter RO_ADDR, default 32'h4000_0014, read-only register address (SYSTICK).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mN_req  input  1  (N=0 CPU MEM stage, N=1 debug/UART bridge) request; held until mN_ack is seen.
REQ-007 mN_we  input  1  1 = write, 0 = read.
REQ-008 mN_addr  input  32  byte address.
REQ-009 mN_wdata  input  32  write data.
REQ-010 mN_rdata  output  32  registered read data; valid while mN_ack=1.
REQ-011 mN_ack  output  1  one-cycle completion pulse.
REQ-012 mN_err  output  1  error flag; valid while mN_ack=1.
REQ-013 peri_cre_o  output  1  slave read enable.
REQ-014 peri_cwe_o  output  1  slave write enable.
REQ-015 peri_addr_o  output  32  slave address.
REQ-016 peri_wdata_o  output  32  slave write data.
REQ-017 peri_rdata_i  input  32  slave combinational read data.

Function
REQ-018 SHALL implement FSM states IDLE, BUS, RESP.
REQ-019 In IDLE, SHALL treat mN as requesting only if mN_req=1 and mN_ack=0 in that cycle.
REQ-020 In IDLE with one requester, SHALL grant it, latch its we/addr/wdata, and go to BUS.
REQ-021 In IDLE with both requesting, SHALL grant the master not recorded in last_gnt; last_gnt SHALL update to the granted master.
REQ-022 In IDLE with no requester, SHALL remain in IDLE with all slave strobes 0.
REQ-023 SHALL classify a latched request as error if addr[1:0]!=0, or addr<PERI_BASE, or addr>PERI_LAST, or (we=1 and addr==RO_ADDR).
REQ-024 In BUS, a non-error request SHALL drive peri_addr_o/peri_wdata_o from latched values, peri_cwe_o=we, peri_cre_o=~we, for exactly one cycle.
REQ-025 In BUS, an error request SHALL keep peri_cre_o=peri_cwe_o=0.
REQ-026 At the end of BUS, SHALL register peri_rdata_i into granted mN_rdata for non-error reads; 0 for writes and errors; go to RESP.
REQ-027 In RESP, SHALL assert granted mN_ack=1 for one cycle, with mN_err=1 iff error, then go to IDLE.
REQ-028 Latency SHALL be: req sampled in IDLE at cycle T -> slave strobe in T+1 -> ack in T+2.
REQ-029 The non-granted master's ack, err and rdata SHALL remain 0/unchanged; it SHALL wait with no request lost.
REQ-030 Back-to-back: the other master SHALL be grantable in the IDLE cycle following RESP; minimum 3 cycles per transaction.
REQ-031 peri_addr_o and peri_wdata_o SHALL be 0 outside BUS.
REQ-032 At most one of peri_cre_o, peri_cwe_o SHALL be 1 in any cycle.
REQ-033 Changes of mN_* inputs while granted SHALL be ignored; latched values are used.

Reset
REQ-034 On rst=1 at a clock edge, SHALL enter IDLE, set last_gnt=1 (m0 wins first tie), clear latched request and all outputs to 0.
REQ-035 A transaction in BUS or RESP when reset is applied SHALL be abandoned with no ack issued.
REQ-036 With rst held high, SHALL grant nothing and keep peri strobes 0.

Verification
REQ-037 m0 read 0x4000_000C with slave returning 0x0000_00A5 -> peri_cre_o=1 at T+1, m0_ack=1, m0_rdata=0x0000_00A5, m0_err=0 at T+2.
REQ-038 m0 and m1 both request in the same cycle after reset, both writes -> m0 granted first, m1 strobe at T+4, m1_ack at T+5; next simultaneous pair grants m0 first again (round robin alternation: last was m1).
REQ-039 m1 write 0x4000_0014 (RO) -> no strobe, m1_ack=1, m1_err=1, m1_rdata=0 at T+2.
REQ-040 m0 read 0x4000_0002 and read 0x4000_0018 -> each: no strobe, m0_err=1 with ack at T+2.
REQ-041 m0 write 0x4000_0000 data 0xFFFF_FF00, rst pulsed in T+1 -> no m0_ack, all outputs 0 after reset, m0 re-request completes normally.
REQ-042 m0 held requesting continuously for 10 transactions while m1 requests -> m1 acked within 6 cycles of its request.
